// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Loads hit with zero wait. Misses refill a whole line over a read burst.
// Every store is forwarded over the write handshake.
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            AddressingControlM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallMem,
  output logic                  mem_rd_req,
  output logic [DATA_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [DATA_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_wr_strb,
  input  logic                  mem_wr_ack
);

  localparam int OFF_BITS   = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS   = $clog2(SETS);
  localparam int TAG_BITS   = DATA_WIDTH - IDX_BITS - OFF_BITS - 2;
  localparam int LINE_WORDS = SETS * WORDS_PER_LINE;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} cacheState_t;

  cacheState_t state, nextState;

  logic [IDX_BITS-1:0]   lineIdx;
  logic [OFF_BITS-1:0]   wordOff;
  logic [TAG_BITS-1:0]   addrTag;
  logic [SETS-1:0]       validBits;
  logic [TAG_BITS-1:0]   tagArr  [SETS];
  logic [DATA_WIDTH-1:0] dataArr [LINE_WORDS];
  logic [OFF_BITS-1:0]   beatCnt;
  logic                  hit;
  logic                  lastBeat;
  logic [DATA_WIDTH-1:0] cachedWord;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] storeData;
  logic [3:0]            storeStrb;
  logic [7:0]            ldByte;
  logic [15:0]           ldHalf;

  assign lineIdx    = ALUResultM[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
  assign wordOff    = ALUResultM[OFF_BITS+1:2];
  assign addrTag    = ALUResultM[DATA_WIDTH-1:IDX_BITS+OFF_BITS+2];
  assign hit        = validBits[lineIdx] && (tagArr[lineIdx] == addrTag);
  assign cachedWord = dataArr[{lineIdx, wordOff}];
  assign lastBeat   = mem_rd_valid && (&beatCnt);
  assign ldByte     = cachedWord[8*ALUResultM[1:0] +: 8];
  assign ldHalf     = cachedWord[16*ALUResultM[1] +: 16];

  // Load result formatting by access size and signedness
  always_comb begin
    loadData = cachedWord;
    case (AddressingControlM)
      3'b000:  loadData = {{(DATA_WIDTH-8){ldByte[7]}}, ldByte};
      3'b001:  loadData = {{(DATA_WIDTH-16){ldHalf[15]}}, ldHalf};
      3'b100:  loadData = {{(DATA_WIDTH-8){1'b0}}, ldByte};
      3'b101:  loadData = {{(DATA_WIDTH-16){1'b0}}, ldHalf};
      default: loadData = cachedWord;
    endcase
  end

  // Store lane replication and byte enables
  always_comb begin
    storeData = WriteDataM;
    storeStrb = 4'b1111;
    case (AddressingControlM[1:0])
      2'b00: begin
        storeData = {(DATA_WIDTH/8){WriteDataM[7:0]}};
        storeStrb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        storeData = {(DATA_WIDTH/16){WriteDataM[15:0]}};
        storeStrb = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        storeData = WriteDataM;
        storeStrb = 4'b1111;
      end
    endcase
  end

  // State, beat counter and valid bits; the line is invalid until its last beat lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beatCnt   <= '0;
      validBits <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && ReqM && !MemWriteM && !hit)
        validBits[lineIdx] <= 1'b0;
      if (state == REFILL && mem_rd_valid) begin
        beatCnt <= beatCnt + OFF_BITS'(1);
        if (lastBeat)
          validBits[lineIdx] <= 1'b1;
      end
    end
  end

  // Tag and data storage: refill beats and store-hit byte merges
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rd_valid) begin
      dataArr[{lineIdx, beatCnt}] <= mem_rd_data;
      if (lastBeat)
        tagArr[lineIdx] <= addrTag;
    end
    if (state == WRITE && mem_wr_ack && hit) begin
      for (int unsigned b = 0; b < 4; b++)
        if (storeStrb[b])
          dataArr[{lineIdx, wordOff}][8*b +: 8] <= storeData[8*b +: 8];
    end
  end

  // Next state and outputs; all outputs are forced low while reset is asserted
  always_comb begin
    nextState   = state;
    StallMem    = 1'b0;
    ReadDataM   = '0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_strb = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (ReqM) begin
            if (MemWriteM) begin
              StallMem  = 1'b1;
              nextState = WRITE;
            end else if (hit) begin
              ReadDataM = loadData;
            end else begin
              StallMem  = 1'b1;
              nextState = REFILL;
            end
          end
        end
        REFILL: begin
          StallMem    = 1'b1;
          mem_rd_req  = 1'b1;
          mem_rd_addr = {ALUResultM[DATA_WIDTH-1:OFF_BITS+2], (OFF_BITS+2)'(0)};
          if (lastBeat)
            nextState = IDLE;
        end
        WRITE: begin
          StallMem    = 1'b1;
          mem_wr_req  = 1'b1;
          mem_wr_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
          mem_wr_data = storeData;
          mem_wr_strb = storeStrb;
          if (mem_wr_ack)
            nextState = RESP;
        end
        RESP: nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed loads/stores, behavioural backing memory.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  AddressingControlM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        mem_rd_req, mem_rd_valid;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req, mem_wr_ack;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_strb;

  always #5 clk = ~clk;

  data_cache #(.DATA_WIDTH(32), .SETS(64), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst), .ReqM(ReqM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .AddressingControlM(AddressingControlM), .ReadDataM(ReadDataM),
    .StallMem(StallMem), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack)
  );

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [31:0] expQ[$];
  logic [31:0] bmem [logic [31:0]];
  int          rdBeats = 0;
  int          wrAcks  = 0;
  int          b0;
  bit          ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed load is compared against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && ReqM && !MemWriteM && !StallMem) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("FAIL loadUnexpected: got 0x%08h, expected no load", ReadDataM);
      end else begin
        check("loadData", ReadDataM, expQ.pop_front());
      end
    end
  end

  // Backing memory read side: beats on alternate cycles while a refill is requested
  initial begin
    bit          gap;
    int          idx;
    logic [31:0] a;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    gap = 1'b0;
    idx = 0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (mem_rd_req) begin
        gap = ~gap;
        if (gap) begin
          a = mem_rd_addr + 32'(idx * 4);
          mem_rd_data  = bmem.exists(a) ? bmem[a] : 32'hDEADBEEF;
          mem_rd_valid = 1'b1;
          idx++;
          rdBeats++;
        end
      end else begin
        gap = 1'b0;
        idx = 0;
      end
    end
  end

  // Backing memory write side: ack on the third cycle of a store request
  initial begin
    int          wait_;
    logic [31:0] w;
    mem_wr_ack = 1'b0;
    wait_ = 0;
    forever begin
      @(negedge clk);
      mem_wr_ack = 1'b0;
      if (mem_wr_req) begin
        wait_++;
        if (wait_ == 3) begin
          mem_wr_ack = 1'b1;
          w = bmem.exists(mem_wr_addr) ? bmem[mem_wr_addr] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (mem_wr_strb[b]) w[8*b +: 8] = mem_wr_data[8*b +: 8];
          bmem[mem_wr_addr] = w;
          wrAcks++;
          wait_ = 0;
        end
      end else begin
        wait_ = 0;
      end
    end
  end

  task automatic doLoad(input string name, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp, input int expStall, input bit expRefill);
    int stall = 0;
    bit saw = 0;
    bit done = 0;
    int start = rdBeats;
    expQ.push_back(exp);
    ReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = addr; AddressingControlM = f3; WriteDataM = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_rd_req && !saw) begin
        saw = 1'b1;
        check({name, "_rdAddr"}, mem_rd_addr, addr & 32'hFFFF_FFF0);
      end
      if (!StallMem) done = 1'b1;
      else stall++;
    end
    if (!done) begin
      nCompared++;
      nMismatched++;
      $display("FAIL %s_timeout: got stall still high, expected release", name);
    end
    check({name, "_stall"}, 32'(stall), 32'(expStall));
    check({name, "_refill"}, 32'(saw), 32'(expRefill));
    check({name, "_beats"}, 32'(rdBeats - start), expRefill ? 32'd4 : 32'd0);
    @(posedge clk); #1;
    ReqM = 1'b0;
  endtask

  task automatic doStore(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, input logic [3:0] expStrb, input logic [31:0] expData);
    int stall = 0;
    bit sawWr = 0;
    bit sawRd = 0;
    bit done = 0;
    int rStart = rdBeats;
    int wStart = wrAcks;
    ReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = addr; AddressingControlM = f3; WriteDataM = wdata;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_rd_req) sawRd = 1'b1;
      if (mem_wr_req && !sawWr) begin
        sawWr = 1'b1;
        check({name, "_wrStrb"}, 32'(mem_wr_strb), 32'(expStrb));
        check({name, "_wrData"}, mem_wr_data, expData);
        check({name, "_wrAddr"}, mem_wr_addr, addr & 32'hFFFF_FFFC);
      end
      if (!StallMem) begin
        done = 1'b1;
        check({name, "_respData"}, ReadDataM, 32'h0);
      end else begin
        stall++;
      end
    end
    if (!done) begin
      nCompared++;
      nMismatched++;
      $display("FAIL %s_timeout: got stall still high, expected release", name);
    end
    check({name, "_stall"}, 32'(stall), 32'd4);
    check({name, "_noRefill"}, 32'(sawRd) + 32'(rdBeats - rStart), 32'd0);
    check({name, "_acks"}, 32'(wrAcks - wStart), 32'd1);
    @(posedge clk); #1;
    ReqM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    ReqM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0; AddressingControlM = '0;
    bmem[32'h100] = 32'hA0; bmem[32'h104] = 32'hA1; bmem[32'h108] = 32'hA2; bmem[32'h10C] = 32'hA3;
    bmem[32'h500] = 32'hB0; bmem[32'h504] = 32'hB1; bmem[32'h508] = 32'hB2; bmem[32'h50C] = 32'hB3;
    bmem[32'h2000] = 32'hC0; bmem[32'h2004] = 32'hC1; bmem[32'h2008] = 32'hC2; bmem[32'h200C] = 32'hC3;
    #1;
    check("rst_stall", 32'(StallMem), 32'd0);
    check("rst_rdReq", 32'(mem_rd_req), 32'd0);
    check("rst_wrReq", 32'(mem_wr_req), 32'd0);
    check("rst_readData", ReadDataM, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    doLoad("lwMiss100", 32'h100, 3'b010, 32'h000000A0, 8, 1'b1);
    doLoad("lwHit10C",  32'h10C, 3'b010, 32'h000000A3, 0, 1'b0);
    doStore("sw100", 32'h100, 3'b010, 32'h80FF7F01, 4'b1111, 32'h80FF7F01);
    doLoad("lb103",  32'h103, 3'b000, 32'hFFFFFF80, 0, 1'b0);
    doLoad("lbu103", 32'h103, 3'b100, 32'h00000080, 0, 1'b0);
    doLoad("lh102",  32'h102, 3'b001, 32'hFFFF80FF, 0, 1'b0);
    doLoad("lhu100", 32'h100, 3'b101, 32'h00007F01, 0, 1'b0);
    doStore("sb101", 32'h101, 3'b000, 32'h000000AA, 4'b0010, 32'hAAAAAAAA);
    doLoad("lwMerged", 32'h100, 3'b010, 32'h80FFAA01, 0, 1'b0);
    doStore("swMiss2000", 32'h2000, 3'b010, 32'h12345678, 4'b1111, 32'h12345678);
    doLoad("lwMiss2000", 32'h2000, 3'b010, 32'h12345678, 8, 1'b1);
    doLoad("lwEvict500", 32'h500, 3'b010, 32'h000000B0, 8, 1'b1);
    doLoad("lwHit504",   32'h504, 3'b010, 32'h000000B1, 0, 1'b0);

    // Reset in the middle of a refill of the evicted 0x100 line
    ReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h100; AddressingControlM = 3'b010;
    b0 = rdBeats;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk);
      if (rdBeats - b0 == 2) ok = 1'b1;
    end
    if (!ok) begin
      nCompared++;
      nMismatched++;
      $display("FAIL rstMid_timeout: got %0d beats, expected 2", rdBeats - b0);
    end
    #2 rst = 1'b0;
    #1;
    check("rstMid_rdReq", 32'(mem_rd_req), 32'd0);
    check("rstMid_stall", 32'(StallMem), 32'd0);
    check("rstMid_wrReq", 32'(mem_wr_req), 32'd0);
    check("rstMid_readData", ReadDataM, 32'h0);
    ReqM = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    doLoad("lwAfterRst", 32'h100, 3'b010, 32'h80FFAA01, 8, 1'b1);
    doLoad("lwHit10Cb",  32'h10C, 3'b010, 32'h000000A3, 0, 1'b0);
    doStore("sh10E", 32'h10E, 3'b001, 32'h00001234, 4'b1100, 32'h12341234);
    doLoad("lwAfterSh", 32'h10C, 3'b010, 32'h123400A3, 0, 1'b0);
    doLoad("lhu10E",    32'h10E, 3'b101, 32'h00001234, 0, 1'b0);
    doLoad("lh10C",     32'h10C, 3'b001, 32'h000000A3, 0, 1'b0);
    doLoad("lb10C",     32'h10C, 3'b000, 32'hFFFFFFA3, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Memory-stage responder for the pipelined CPU: services the load/store requests the pipeline issues in M (address, write data, store enable, funct3 access size).
- Returns formatted load data and raises a stall while an access is outstanding.
- Direct-mapped, write-through, no-write-allocate. Refills multi-word lines from a backing memory over a read-burst handshake; forwards every store over a write handshake.

Parameters:
- DATA_WIDTH, 32, CPU word and backing-memory beat width.
- SETS, 64, number of lines (power of 2; index = addr[3+log2(SETS):4] at defaults).
- WORDS_PER_LINE, 4, words per line (power of 2; offset = addr[log2(WORDS_PER_LINE)+1:2]).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ReqM  in  1  valid load/store in M this cycle.
- MemWriteM  in  1  1 = store, 0 = load.
- ALUResultM  in  DATA_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data, right-aligned.
- AddressingControlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ReadDataM  out  DATA_WIDTH  formatted load result.
- StallMem  out  1  hold M and all earlier stages.
- mem_rd_req  out  1  line refill request, held for the whole burst.
- mem_rd_addr  out  DATA_WIDTH  line-aligned refill address.
- mem_rd_valid  in  1  one refill beat valid.
- mem_rd_data  in  DATA_WIDTH  refill beat, words delivered in order 0..WORDS_PER_LINE-1.
- mem_wr_req  out  1  store request.
- mem_wr_addr  out  DATA_WIDTH  word-aligned store address.
- mem_wr_data  out  DATA_WIDTH  store data shifted into byte lanes.
- mem_wr_strb  out  4  byte enables.
- mem_wr_ack  in  1  store accepted.

Behaviour:
- Reset (rst=0, async): all valid bits cleared; state IDLE; beat counter 0; every output 0.
- Reset mid-burst or mid-store: request drops immediately; any partially filled line stays invalid.
- Address split: tag = addr[31:log2(SETS)+log2(WORDS_PER_LINE)+2], then index, word offset, byte offset.
- Hit = valid[index] and tag match.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE
  - No ReqM: StallMem=0.
  - Load hit: ReadDataM valid combinationally this cycle, StallMem=0, stay IDLE (zero-wait).
  - Load miss: StallMem=1 this cycle; clear valid[index]; go REFILL.
  - Store (hit or miss): StallMem=1; go WRITE.
- REFILL
  - mem_rd_req=1; mem_rd_addr = addr with offset bits zeroed; StallMem=1.
  - Each mem_rd_valid writes mem_rd_data to word[counter] and increments counter.
  - On the last beat: set tag and valid, reset counter, go IDLE. The next cycle re-looks-up and hits.
  - Miss penalty = WORDS_PER_LINE beats + 1 cycle.
- WRITE
  - mem_wr_req=1, StallMem=1.
  - Strobes: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111.
  - mem_wr_data = byte/half replicated into its lanes.
  - On mem_wr_ack: if hit, merge the strobed bytes into the cached word; go RESP.
  - Store miss never allocates.
- RESP
  - StallMem=0 for one cycle so the pipeline advances past the completed store; no lookup this cycle; go IDLE.
- Load formatting from the selected word:
  - LB/LBU: byte addr[1:0], sign-/zero-extended.
  - LH/LHU: half addr[1], sign-/zero-extended.
  - LW: whole word.
  - Misalignment is not checked; lower address bits are ignored per size.
- ReadDataM = 0 when not (IDLE and load hit).
- The CPU holds all M inputs stable while StallMem=1.
- mem_rd_valid outside REFILL and mem_wr_ack outside WRITE are ignored.
- Counter wraps to 0 after the last beat.

Test Plan:
- Reset, then LW 0x100 miss → StallMem=1, mem_rd_req=1, mem_rd_addr=0x100; beats 0xA0,0xA1,0xA2,0xA3 with gaps → StallMem falls 1 cycle after the last beat, ReadDataM=0xA0; LW 0x10C then hits with 0 stall, returns 0xA3.
- Line holds word 0x80FF7F01 at 0x100 → LB 0x103 = 0xFFFFFF80, LBU 0x103 = 0x00000080, LH 0x102 = 0xFFFF80FF, LHU 0x100 = 0x00007F01, all with no stall.
- SB 0x101 data 0x000000AA (hit), ack after 3 cycles → mem_wr_strb=0010, mem_wr_data=0xAAAAAAAA lane-valid, StallMem=1 for 4 cycles then 0 for 1 (RESP); LW 0x100 returns 0x80FFAA01 without refill.
- SW 0x2000 miss → write only, mem_rd_req never asserted; following LW 0x2000 misses and refills.
- LW 0x100 then LW 0x500 (same index 16, different tag) → second refills and evicts; LW 0x100 misses again.
- rst low after 2 of 4 refill beats → mem_rd_req=0 and StallMem=0 immediately; after release, LW 0x100 misses and issues a full 4-beat refill.
